// File: rtl/mux_arbiter_pkg.sv
// Shared constants for the two-requester arbiter: source IDs and output-buffer state encodings.
// Pure declarations: no logic, no latency, no backpressure.
package mux_arbiter_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/mux_arbiter_mux.sv
// WIDTH-bit 2:1 data mux: sel_i=0 passes a_i, sel_i=1 passes b_i.
// Purely combinational, zero latency, no flow control.
module mux #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter of two valid/ready requesters into a one-entry registered output buffer.
// 1-cycle latency; drains and reloads in the same cycle, and both readies drop while the buffer stalls.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_src_q, last_src_d;

    logic             grant_vld;
    logic             grant_src;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] mux_dat;

    mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a_i   (a_data),
        .b_i   (b_data),
        .sel_i (grant_src),
        .y_o   (mux_dat)
    );

    // last_src is only updated on loads, so the grant is frozen while the buffer stalls.
    always_comb begin
        grant_vld = a_valid | b_valid;
        if (a_valid && b_valid) begin
            grant_src = ~last_src_q;
        end else if (b_valid) begin
            grant_src = SRC_B;
        end else begin
            grant_src = SRC_A;
        end
        can_load = (state_q == EMPTY) || out_ready;
        // rst_n gates the readies so nothing is accepted while reset is held.
        load     = can_load && grant_vld && rst_n;
    end

    assign a_ready = load && (grant_src == SRC_A);
    assign b_ready = load && (grant_src == SRC_B);

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        last_src_d = last_src_q;
        if (load) begin
            state_d    = FULL;
            out_data_d = mux_dat;
            out_src_d  = grant_src;
            last_src_d = grant_src;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= SRC_A;
            last_src_q <= SRC_B;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            last_src_q <= last_src_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed vector table, reset corner sequences and a randomised scoreboard for mux_arbiter.
module tb_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, out_ready;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, out_valid, out_src;
    logic [31:0] out_data;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    typedef struct {
        logic        av;
        logic [31:0] ad;
        logic        bv;
        logic [31:0] bd;
        logic        ordy;
        logic        ear;
        logic        ebr;
        logic        eov;
        logic [31:0] eod;
        logic        esrc;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic av, logic [31:0] ad, logic bv, logic [31:0] bd, logic ordy,
                                logic ear, logic ebr, logic eov, logic [31:0] eod, logic esrc);
        vec_t v;
        v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
        v.ear = ear; v.ebr = ebr; v.eov = eov; v.eod = eod; v.esrc = esrc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [31:0] ad, input logic bv,
                         input logic [31:0] bd, input logic ordy);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    endtask

    int          a_idx, b_idx, a_out, b_out;
    logic        a_x, b_x, stall_pend;
    logic [31:0] stall_dat;

    task automatic pop_check();
        if (out_valid && out_ready) begin
            if (out_src) begin
                chk("rand_b_order", out_data, 32'hB000_0000 + 32'(b_out));
                b_out++;
            end else begin
                chk("rand_a_order", out_data, 32'hA000_0000 + 32'(a_out));
                a_out++;
            end
        end
    endtask

    initial begin
        // Directed table: state carried from one row to the next, starting just after reset.
        vecs[0]  = mk(1, 32'h1234_5678, 0, 32'h0,         1, 1, 0, 1, 32'h1234_5678, 0);
        vecs[1]  = mk(0, 32'h0,         1, 32'h0000_0055, 1, 0, 1, 1, 32'h0000_0055, 1);
        vecs[2]  = mk(1, 32'h1111_2222, 1, 32'h8765_4321, 1, 1, 0, 1, 32'h1111_2222, 0);
        vecs[3]  = mk(1, 32'h1111_2222, 1, 32'h8765_4321, 1, 0, 1, 1, 32'h8765_4321, 1);
        vecs[4]  = mk(1, 32'h1111_2222, 1, 32'h8765_4321, 1, 1, 0, 1, 32'h1111_2222, 0);
        vecs[5]  = mk(1, 32'h1111_2222, 1, 32'h8765_4321, 1, 0, 1, 1, 32'h8765_4321, 1);
        vecs[6]  = mk(0, 32'h0,         1, 32'd122,       1, 0, 1, 1, 32'd122,       1);
        vecs[7]  = mk(0, 32'h0,         0, 32'h0,         1, 0, 0, 0, 32'd122,       1);
        vecs[8]  = mk(0, 32'h0,         1, 32'd122,       1, 0, 1, 1, 32'd122,       1);
        vecs[9]  = mk(1, 32'hAAAA_0001, 1, 32'hBBBB_0001, 0, 0, 0, 1, 32'd122,       1);
        vecs[10] = mk(1, 32'hAAAA_0001, 1, 32'hBBBB_0001, 0, 0, 0, 1, 32'd122,       1);
        vecs[11] = mk(1, 32'hAAAA_0001, 1, 32'hBBBB_0001, 0, 0, 0, 1, 32'd122,       1);
        vecs[12] = mk(1, 32'hAAAA_0001, 1, 32'hBBBB_0001, 1, 1, 0, 1, 32'hAAAA_0001, 0);
        vecs[13] = mk(1, 32'h0000_00F0, 0, 32'h0,         1, 1, 0, 1, 32'h0000_00F0, 0);
        vecs[14] = mk(0, 32'h0,         0, 32'h0,         0, 0, 0, 1, 32'h0000_00F0, 0);

        rst_n = 1'b0;
        drive(1, 32'hDEAD_BEEF, 1, 32'hCAFE_F00D, 1);
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  out_data,       0);
        chk("rst_out_src",   32'(out_src),   0);
        chk("rst_a_ready",   32'(a_ready),   0);
        chk("rst_b_ready",   32'(b_ready),   0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
            #4;
            chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
            chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            chk($sformatf("vec%0d_out_data", i),  out_data,       vecs[i].eod);
            chk($sformatf("vec%0d_out_src", i),   32'(out_src),   32'(vecs[i].esrc));
        end

        // Asynchronous reset while FULL with 32'hF0 (last grant was A, so B would win next).
        drive(1, 32'hAAAA_0002, 1, 32'hBBBB_0002, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_out_data",  out_data,       0);
        chk("async_rst_a_ready",   32'(a_ready),   0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_a_ready", 32'(a_ready), 1);
        chk("post_rst_b_ready", 32'(b_ready), 0);
        @(posedge clk); #1;
        chk("post_rst_out_data", out_data,       32'hAAAA_0002);
        chk("post_rst_out_src",  32'(out_src),   0);
        drive(0, 0, 0, 0, 1);
        @(posedge clk); #1;
        chk("drain_out_valid", 32'(out_valid), 0);

        // Random valid/ready traffic; each source sends an incrementing tagged sequence.
        a_idx = 0; b_idx = 0; a_out = 0; b_out = 0; stall_pend = 1'b0; stall_dat = '0;
        for (int i = 0; i < 400; i++) begin
            if (!a_valid && $urandom_range(0, 2) != 0) begin
                a_valid = 1'b1;
                a_data  = 32'hA000_0000 + 32'(a_idx);
            end
            if (!b_valid && $urandom_range(0, 2) != 0) begin
                b_valid = 1'b1;
                b_data  = 32'hB000_0000 + 32'(b_idx);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (stall_pend) begin
                chk("rand_stall_valid", 32'(out_valid), 1);
                chk("rand_stall_data",  out_data,       stall_dat);
            end
            chk("rand_ready_excl", 32'(a_ready & b_ready), 0);
            a_x = a_valid && a_ready;
            b_x = b_valid && b_ready;
            pop_check();
            stall_pend = out_valid && !out_ready;
            stall_dat  = out_data;
            @(posedge clk); #1;
            if (a_x) begin a_idx++; a_valid = 1'b0; end
            if (b_x) begin b_idx++; b_valid = 1'b0; end
        end
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            pop_check();
            @(posedge clk); #1;
        end
        chk("rand_a_count", 32'(a_out), 32'(a_idx));
        chk("rand_b_count", 32'(b_out), 32'(b_idx));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
